// File: rtl/dma_resp_queue_pkg.sv
// Shared types for the DMA completion-response queue: record width and the
// packed {ch_sel, desc_id} completion record.
package dma_resp_queue_pkg;

   localparam int DMA_RESP_CH_WIDTH  = 2;
   localparam int DMA_RESP_ID_WIDTH  = 8;
   localparam int DMA_RESP_REC_WIDTH = 10;

   typedef struct packed {
      logic [1:0] ch_sel;
      logic [7:0] desc_id;
   } dma_resp_rec_t;

endpackage

// File: rtl/dma_resp_queue_if.sv
// Arbiter-side write handshake and APB-side show-ahead read port of the
// completion-response queue.
interface dma_resp_queue_if;
   import dma_resp_queue_pkg::*;

   logic                          i_resp_wr;
   logic [DMA_RESP_ID_WIDTH-1:0]  i_resp_desc_id;
   logic [DMA_RESP_CH_WIDTH-1:0]  i_resp_ch_sel;
   logic                          o_resp_wready;
   logic                          o_rvalid;
   logic [DMA_RESP_REC_WIDTH-1:0] o_rdata;
   logic                          i_pop;

   modport master (
      output i_resp_wr, i_resp_desc_id, i_resp_ch_sel, i_pop,
      input  o_resp_wready, o_rvalid, o_rdata
   );

   modport slave (
      input  i_resp_wr, i_resp_desc_id, i_resp_ch_sel, i_pop,
      output o_resp_wready, o_rvalid, o_rdata
   );

endinterface

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO core: register-array storage with wrap-bit pointers.
// Callers qualify push/pop; flush returns both pointers to zero.
module dma_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;

   // Storage is deliberately not reset; an empty queue masks it downstream.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

   // Pointer update; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r[AW-1:0]];
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

endmodule

// File: rtl/dma_resp_queue.sv
// DMA completion-response queue: FIFO wrapper adding occupancy count, flush and
// a sticky threshold interrupt (present only when DMA_RESP_IRQ_EN is defined).
module dma_resp_queue
   import dma_resp_queue_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int IRQ_THRESH = 1
) (
   input  logic                  aclk,
   input  logic                  anreset,
   input  logic                  aenable,
   input  logic                  i_flush,
   dma_resp_queue_if.slave       resp,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                  o_full,
   output logic                  o_irq,
   input  logic                  i_irq_clr
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                          flush_s;
   logic                          wready_s;
   logic                          push_s;
   logic                          pop_s;
   logic                          empty_s;
   logic                          full_s;
   dma_resp_rec_t                 wr_rec_s;
   logic [DMA_RESP_REC_WIDTH-1:0] fifo_rdata_s;
   logic [CW-1:0]                 count_r;

   // A disabled block ignores flush as well, so every piece of state freezes.
   assign flush_s  = aenable & i_flush;
   assign wready_s = anreset & aenable & ~i_flush & ~full_s;
   assign push_s   = resp.i_resp_wr & wready_s;
   assign pop_s    = resp.i_pop & ~empty_s & aenable & ~i_flush;
   assign wr_rec_s = '{ch_sel: resp.i_resp_ch_sel, desc_id: resp.i_resp_desc_id};

   dma_sync_fifo #(
      .WIDTH (DMA_RESP_REC_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (aclk),
      .rst_n (anreset),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (wr_rec_s),
      .rdata (fifo_rdata_s),
      .empty (empty_s),
      .full  (full_s)
   );

   // Read port and status; unreset storage is hidden while the queue is empty.
   always_comb begin
      resp.o_resp_wready = wready_s;
      resp.o_rvalid      = ~empty_s;
      o_full             = full_s;
      o_count            = count_r;
      if (!empty_s) begin
         resp.o_rdata = fifo_rdata_s;
      end else begin
         resp.o_rdata = '0;
      end
   end

   // Occupancy counter kept as its own register rather than a pointer difference.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         count_r <= '0;
      end else if (flush_s) begin
         count_r <= '0;
      end else if (push_s && !pop_s) begin
         count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (pop_s && !push_s) begin
         count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

`ifdef DMA_RESP_IRQ_EN
   logic irq_r;
   logic irq_set_s;

   assign irq_set_s = push_s & ~pop_s & ((count_r + {{(CW-1){1'b0}}, 1'b1}) >= CW'(IRQ_THRESH));

   // Sticky interrupt; a coincident set beats the clear.
   always_ff @(posedge aclk or negedge anreset) begin
      if (!anreset) begin
         irq_r <= 1'b0;
      end else if (!aenable) begin
         irq_r <= irq_r;
      end else if (irq_set_s) begin
         irq_r <= 1'b1;
      end else if (i_irq_clr) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= irq_r;
      end
   end

   assign o_irq = irq_r;
`else
   wire unused_ok_s = &{1'b0, i_irq_clr, (IRQ_THRESH > 0)};

   assign o_irq = 1'b0;
`endif

endmodule
